// File: rtl/seq_restoring_divider_2n_n.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_2n_n
//  Purpose  : Iterative radix-2 restoring divider, 2N-bit dividend by N-bit
//             divisor, one quotient bit per clock behind start/busy/done.
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider_2n_n #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] D,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   Rem,
  output logic           busy,
  output logic           done,
  output logic           dz,
  output logic           ovf
);

  localparam int            c_cw        = $clog2(N + 1);
  localparam logic [0:0]    c_st_idle   = 1'b0;
  localparam logic [0:0]    c_st_run    = 1'b1;
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(N - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [N-1:0]    r_b;
  logic [N:0]      r_p;
  logic [N-1:0]    r_s;
  logic [c_cw-1:0] r_count;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_rem;
  logic            r_done;
  logic            r_dz;
  logic            r_ovf;

  logic            w_accept;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_last;
  logic [N:0]      w_t;
  logic            w_ge;
  logic [N:0]      w_p_step;
  logic [N-1:0]    w_s_step;

  // Start qualification and error classification on the live inputs
  assign w_accept   = (r_state == c_st_idle) && start;
  assign w_div_zero = (B == '0);
  assign w_overflow = !w_div_zero && (D[2*N-1:N] >= B);
  assign w_last     = (r_count == c_last_cnt);

  // One restoring step: shift the next dividend bit in, trial-subtract.
  // P < B holds before every step, so T < 2B always fits in N+1 bits.
  assign w_t      = {r_p[N-1:0], r_s[N-1]};
  assign w_ge     = (w_t >= {1'b0, r_b});
  assign w_p_step = w_ge ? (w_t - {1'b0, r_b}) : w_t;
  assign w_s_step = {r_s[N-2:0], w_ge};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // Next-state logic: error cases finish in IDLE, normal starts enter RUN
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept && !w_div_zero && !w_overflow) w_state_next = c_st_run;
      c_st_run:  if (w_last) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (r_state == c_st_run);
    done = r_done;
    Q    = r_q;
    Rem  = r_rem;
    dz   = r_dz;
    ovf  = r_ovf;
  end

  // Datapath and result registers; results only move at completion or error start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b     <= '0;
      r_p     <= '0;
      r_s     <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (w_div_zero) begin
              r_q    <= '1;
              r_rem  <= D[N-1:0];
              r_dz   <= 1'b1;
              r_ovf  <= 1'b0;
              r_done <= 1'b1;
            end else if (w_overflow) begin
              r_q    <= '1;
              r_rem  <= '1;
              r_dz   <= 1'b0;
              r_ovf  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_b     <= B;
              r_p     <= {1'b0, D[2*N-1:N]};
              r_s     <= D[N-1:0];
              r_count <= '0;
              r_dz    <= 1'b0;
              r_ovf   <= 1'b0;
            end
          end
        end
        c_st_run: begin
          r_p     <= w_p_step;
          r_s     <= w_s_step;
          r_count <= r_count + c_cw'(1);
          if (w_last) begin
            r_q    <= w_s_step;
            r_rem  <= w_p_step[N-1:0];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
